// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX boundary bundle: decode-side beat, execute-side beat, handshake and flush.
// No logic; the modports fix direction for the pipeline register (slave) and its environment (master).
// Backpressure is carried by in_ready / out_ready.
interface id_ex_pipe_reg_if #(
    parameter int DW = 32,
    parameter int JW = 26,
    parameter int CW = 16
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [JW-1:0] low26_d;
    logic [DW-1:0] rs_d;
    logic [DW-1:0] rt_d;
    logic [CW-1:0] ctrl_d;
    logic [DW-1:0] pc4_d;
    logic          out_valid;
    logic          out_ready;
    logic [JW-1:0] low26_e;
    logic [DW-1:0] rs_e;
    logic [DW-1:0] rt_e;
    logic [CW-1:0] ctrl_e;
    logic [DW-1:0] pc4_e;

    // Pipeline register view
    modport slave (
        input  flush, in_valid, low26_d, rs_d, rt_d, ctrl_d, pc4_d, out_ready,
        output in_ready, out_valid, low26_e, rs_e, rt_e, ctrl_e, pc4_e
    );

    // Decode/execute stage view
    modport master (
        output flush, in_valid, low26_d, rs_d, rt_d, ctrl_d, pc4_d, out_ready,
        input  in_ready, out_valid, low26_e, rs_e, rt_e, ctrl_e, pc4_e
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready, stall hold, flush and bubble insertion (optional skid entry: ID_EX_SKID_EN).
// Latency: 1 cycle from accepted beat to out_valid.
// Backpressure: base mode in_ready = !out_valid || out_ready || flush; skid mode in_ready = !skid_valid || flush (registered).
module id_ex_pipe_reg #(
    parameter int DW = 32,
    parameter int JW = 26,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_pipe_reg_if.slave  bus
);

    typedef struct packed {
        logic [JW-1:0] low26;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] pc4;
    } beat_t;

    beat_t w_in_beat;
    beat_t r_main;
    logic  r_out_valid;
    logic  w_in_ready;

    assign w_in_beat = '{low26: bus.low26_d, rs: bus.rs_d, rt: bus.rt_d,
                         ctrl: bus.ctrl_d, pc4: bus.pc4_d};

`ifdef ID_EX_SKID_EN
    beat_t r_skid;
    logic  r_skid_valid;
    logic  w_release;
    logic  w_accept;

    // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally
    assign w_in_ready = !r_skid_valid || bus.flush;
    assign w_release  = r_out_valid && bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    // Two-entry FIFO: main feeds EX, skid catches the beat accepted while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_main       <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (bus.flush) begin
            r_out_valid  <= 1'b0;
            r_main.ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid.ctrl  <= '0;
        end else if (!r_out_valid || w_release) begin
            // Main is free this edge: the older skid beat goes first, otherwise the input
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_skid.ctrl  <= '0;
            end else if (w_accept) begin
                r_main      <= w_in_beat;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
                r_main.ctrl <= '0;
            end
        end else if (w_accept) begin
            r_skid       <= w_in_beat;
            r_skid_valid <= 1'b1;
        end
    end
`else
    // Single entry: a slot opens when empty, draining this cycle, or being flushed
    assign w_in_ready = !r_out_valid || bus.out_ready || bus.flush;

    // Flush kills the entry; otherwise load, bubble, or hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_main      <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_main.ctrl <= '0;
        end else if (w_in_ready) begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_main <= w_in_beat;
            end else begin
                // Bubble: zeroed control bundle is a NOP; data fields keep their last value
                r_main.ctrl <= '0;
            end
        end
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.low26_e   = r_main.low26;
    assign bus.rs_e      = r_main.rs;
    assign bus.rt_e      = r_main.rt;
    assign bus.ctrl_e    = r_main.ctrl;
    assign bus.pc4_e     = r_main.pc4;

endmodule
